accel_spi_responder: RTL
========================

ACCEL_SPI_RESPONDER -- requirements
Module: accel_spi_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of synchronizer flops on spi_sclk, spi_mosi and spi_cs.
REQ-002 SHALL have parameter DEVID, default 8'hE5: read-only value of register 0x00.
REQ-003 SHALL have port sys_clk, input, 1 bit: the single clock; every flop SHALL be on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port spi_sclk, input, 1 bit: SPI clock from the master, asynchronous to sys_clk, idles high.
REQ-006 SHALL have port spi_mosi, input, 1 bit: serial data from the master.
REQ-007 SHALL have port spi_cs, input, 1 bit: active-low chip select.
REQ-008 SHALL have port spi_miso, output, 1 bit: serial data to the master.
REQ-009 SHALL have port spi_miso_oe, output, 1 bit: MISO drive enable; the top level tri-states the pad when it is 0.
REQ-010 SHALL have ports x_sample, y_sample and z_sample, input, 16 bits each: two's-complement axis samples.
REQ-011 SHALL have port sample_valid, input, 1 bit: a one-cycle pulse that captures x_sample, y_sample and z_sample.
REQ-012 SHALL have port int1, output, 1 bit: active-high DATA_READY interrupt.
REQ-013 SHALL have port reg_wr, output, 1 bit: one-cycle pulse per committed register write.
REQ-014 SHALL have ports reg_wr_addr (6 bits) and reg_wr_data (8 bits), outputs: address and data of the committed write, valid while reg_wr=1.

Function
REQ-015 SHALL implement SPI mode 3: MOSI sampled on SCLK rising; MISO updated on SCLK falling; MSB first.
REQ-016 SHALL detect SCLK and CS edges from the synchronized signals only.
- SHALL operate correctly for sys_clk >= 8x SCLK.
- Edge-to-action latency SHALL be SYNC_STAGES+1 cycles.
REQ-017 SHALL implement FSM states IDLE, CMD and DATA.
- IDLE->CMD on CS falling; bit counter cleared.
- CMD->DATA after the 8th rising edge.
- Any state->IDLE on CS rising.
REQ-018 Command byte format SHALL be: bit7 R/W (1 = read), bit6 MB (multi-byte), bits5:0 start address.
REQ-019 Read: SHALL load the shift register with reg[addr] on the 8th command rising edge and drive bit7 on the following falling edge.
REQ-020 Write: SHALL assemble 8 MOSI bits, then on the 8th rising edge commit to writable registers and pulse reg_wr.
REQ-021 MB=1: SHALL increment the address after each data byte, wrapping 0x3F->0x00.
REQ-022 MB=0: after the first data byte, SHALL output 0 on further read bits and ignore further write bytes.
REQ-023 Register map:
- 64x8 register file.
- 0x00 = DEVID.
- 0x30 INT_SOURCE: bit7 DATA_READY.
- 0x32/0x33 = x[7:0]/x[15:8]; 0x34/0x35 = y; 0x36/0x37 = z.
- 0x00, 0x30 and 0x32-0x37 are read-only: writes are ignored and reg_wr is not pulsed.
- All other addresses are read/write.
REQ-024 sample_valid SHALL write a staging buffer.
- With CS high: staging is committed to 0x32-0x37 on the next cycle.
- During a transaction: commit is deferred to the cycle after CS rises, so reads are always atomic.
- A later sample_valid overwrites pending staging.
REQ-025 A commit SHALL set DATA_READY.
- Reading any of 0x32-0x37 SHALL clear DATA_READY at CS rise.
- A commit in the same cycle as that clear SHALL win, leaving DATA_READY set.
REQ-026 spi_miso_oe SHALL equal 1 only in DATA state of a read; spi_miso SHALL be 0 whenever spi_miso_oe=0.
REQ-027 CS rising mid-byte SHALL discard the partial byte; no reg_wr pulse.

Reset
REQ-028 On reset SHALL set: FSM = IDLE; spi_miso, spi_miso_oe, int1 and reg_wr = 0; reg_wr_addr and reg_wr_data = 0.
REQ-029 On reset SHALL set: all registers = 0 except 0x00 = DEVID and 0x2C = 8'h0A; staging and pending flag cleared.
REQ-030 Reset asserted mid-transaction SHALL abort it; the block SHALL ignore SPI activity until the next CS falling edge after reset deasserts.

Configuration
REQ-031 With macro ACCEL_RESP_INT_EN defined: int1 = DATA_READY AND reg[0x2E] bit7, registered, 1-cycle latency.
REQ-032 Without ACCEL_RESP_INT_EN: int1 tied 0, DATA_READY still visible in 0x30.

Verification
REQ-033 Reset, then read cmd 0x80 -> MISO returns 0xE5, spi_miso_oe high only during the data byte.
REQ-034 sample_valid with x=0x1234, y=0xFFFE, z=0x0100, then MB read cmd 0xF2 of 6 bytes -> 34 12 FE FF 00 01; DATA_READY cleared after CS rise.
REQ-035 Write cmd 0x2D data 0x08 -> reg_wr pulse, addr 0x2D, data 0x08; readback 0x08. Write to 0x32 -> no pulse, value unchanged.
REQ-036 sample_valid mid-burst read -> burst returns the old sample; new sample readable after CS rise.
REQ-037 With ACCEL_RESP_INT_EN: write 0x2E=0x80, then sample_valid -> int1=1; read 0x32 -> int1=0 after CS rise. Without the macro -> int1 stays 0.
REQ-038 CS raised after 4 data bits of write to 0x2D -> no reg_wr, register unchanged. MB read from 0x3F for 2 bytes -> reg[0x3F] then 0xE5.

Source files
------------

// File: rtl/accel_spi_responder.sv
// accel_spi_responder: SPI mode-3 register-file responder for a 3-axis accelerometer.
// Build macro ACCEL_RESP_INT_EN drives int1 from DATA_READY gated by register 0x2E bit 7.
module accel_spi_responder #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] DEVID       = 8'hE5
) (
   input  logic        sys_clk,
   input  logic        reset,
   input  logic        spi_sclk,
   input  logic        spi_mosi,
   input  logic        spi_cs,
   output logic        spi_miso,
   output logic        spi_miso_oe,
   input  logic [15:0] x_sample,
   input  logic [15:0] y_sample,
   input  logic [15:0] z_sample,
   input  logic        sample_valid,
   output logic        int1,
   output logic        reg_wr,
   output logic [5:0]  reg_wr_addr,
   output logic [7:0]  reg_wr_data
);

   typedef enum logic [1:0] {IDLE, CMD, DATA} state_e;

   function automatic logic is_sample(input logic [5:0] a);
      return (a >= 6'h32) && (a <= 6'h37);
   endfunction

   function automatic logic is_writable(input logic [5:0] a);
      return !((a == 6'h00) || (a == 6'h30) || is_sample(a));
   endfunction

   logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, cs_sync_q;
   logic [SYNC_STAGES:0]   sclk_pipe, mosi_pipe, cs_pipe;
   logic                   sclk_prev_q, cs_prev_q;
   logic                   sclk_s, mosi_s, cs_s;
   logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

   state_e      state_q, state_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [6:0]  rx_q, rx_d;
   logic [7:0]  tx_q, tx_d;
   logic [7:0]  shift_in;
   logic        rw_q, rw_d, mb_q, mb_d, done_q, done_d;
   logic        rd_smp_q, rd_smp_d, miso_q, miso_d;
   logic [5:0]  addr_q, addr_d, rd_addr;
   logic [7:0]  rd_byte;
   logic [7:0]  regs_q [64];
   logic [47:0] stage_q;
   logic        pend_q, commit;
   logic        dr_q, dr_d;
   logic        reg_wr_q, reg_wr_d;
   logic [5:0]  wr_addr_q, wr_addr_d;
   logic [7:0]  wr_data_q, wr_data_d;
   logic        int1_q, int1_d;

   assign sclk_pipe = {sclk_sync_q, spi_sclk};
   assign mosi_pipe = {mosi_sync_q, spi_mosi};
   assign cs_pipe   = {cs_sync_q, spi_cs};
   assign sclk_s    = sclk_pipe[SYNC_STAGES];
   assign mosi_s    = mosi_pipe[SYNC_STAGES];
   assign cs_s      = cs_pipe[SYNC_STAGES];
   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s & sclk_prev_q;
   assign cs_rise   = cs_s & ~cs_prev_q;
   assign cs_fall   = ~cs_s & cs_prev_q;

   assign shift_in = {rx_q, mosi_s};
   assign commit   = pend_q && (state_q == IDLE);
   assign rd_addr  = (state_q == CMD) ? shift_in[5:0] : addr_q + 6'd1;

   always_comb begin
      if (rd_addr == 6'h00)      rd_byte = DEVID;
      else if (rd_addr == 6'h30) rd_byte = {dr_q, 7'b0};
      else                       rd_byte = regs_q[rd_addr];
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      rx_d      = rx_q;
      tx_d      = tx_q;
      rw_d      = rw_q;
      mb_d      = mb_q;
      done_d    = done_q;
      rd_smp_d  = rd_smp_q;
      miso_d    = miso_q;
      addr_d    = addr_q;
      dr_d      = dr_q;
      reg_wr_d  = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      if (cs_rise) begin
         state_d  = IDLE;
         rd_smp_d = 1'b0;
         if (rd_smp_q) dr_d = 1'b0;
      end else if (cs_fall && (state_q == IDLE)) begin
         state_d   = CMD;
         bit_cnt_d = '0;
         done_d    = 1'b0;
         miso_d    = 1'b0;
         tx_d      = '0;
         rd_smp_d  = 1'b0;
      end else if (state_q != IDLE) begin
         if (sclk_rise) begin
            rx_d      = shift_in[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
               if (state_q == CMD) begin
                  state_d = DATA;
                  rw_d    = shift_in[7];
                  mb_d    = shift_in[6];
                  addr_d  = shift_in[5:0];
                  if (shift_in[7]) begin
                     tx_d = rd_byte;
                     if (is_sample(rd_addr)) rd_smp_d = 1'b1;
                  end
               end else begin
                  done_d = 1'b1;
                  if (!rw_q && (mb_q || !done_q) && is_writable(addr_q)) begin
                     reg_wr_d  = 1'b1;
                     wr_addr_d = addr_q;
                     wr_data_d = shift_in;
                  end
                  if (mb_q) addr_d = addr_q + 6'd1;
                  // Single-byte reads stream zeros after the first byte.
                  if (rw_q && mb_q) begin
                     tx_d = rd_byte;
                     if (is_sample(rd_addr)) rd_smp_d = 1'b1;
                  end else if (rw_q) begin
                     tx_d = '0;
                  end
               end
            end
         end else if (sclk_fall && (state_q == DATA) && rw_q) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
         end
      end
      // A staging commit outranks the read-triggered clear.
      if (commit) dr_d = 1'b1;
   end

`ifdef ACCEL_RESP_INT_EN
   assign int1_d = dr_q & regs_q[6'h2E][7];
`else
   assign int1_d = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         sclk_sync_q <= '1;
         mosi_sync_q <= '0;
         // CS chain resets low so a select held across reset never looks like a fresh falling edge.
         cs_sync_q   <= '0;
         sclk_prev_q <= 1'b1;
         cs_prev_q   <= 1'b0;
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         rx_q        <= '0;
         tx_q        <= '0;
         rw_q        <= 1'b0;
         mb_q        <= 1'b0;
         done_q      <= 1'b0;
         rd_smp_q    <= 1'b0;
         miso_q      <= 1'b0;
         addr_q      <= '0;
         stage_q     <= '0;
         pend_q      <= 1'b0;
         dr_q        <= 1'b0;
         reg_wr_q    <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         int1_q      <= 1'b0;
      end else begin
         sclk_sync_q <= sclk_pipe[SYNC_STAGES-1:0];
         mosi_sync_q <= mosi_pipe[SYNC_STAGES-1:0];
         cs_sync_q   <= cs_pipe[SYNC_STAGES-1:0];
         sclk_prev_q <= sclk_s;
         cs_prev_q   <= cs_s;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_q        <= rx_d;
         tx_q        <= tx_d;
         rw_q        <= rw_d;
         mb_q        <= mb_d;
         done_q      <= done_d;
         rd_smp_q    <= rd_smp_d;
         miso_q      <= miso_d;
         addr_q      <= addr_d;
         dr_q        <= dr_d;
         reg_wr_q    <= reg_wr_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         int1_q      <= int1_d;
         if (sample_valid) begin
            stage_q <= {z_sample, y_sample, x_sample};
            pend_q  <= 1'b1;
         end else if (commit) begin
            pend_q  <= 1'b0;
         end
      end
   end

   // NOTE: this register file is reset because its power-up contents are architecturally visible.
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         regs_q         <= '{default: 8'h00};
         regs_q[6'h2C]  <= 8'h0A;
      end else begin
         if (reg_wr_d) regs_q[wr_addr_d] <= wr_data_d;
         if (commit) begin
            regs_q[6'h32] <= stage_q[7:0];
            regs_q[6'h33] <= stage_q[15:8];
            regs_q[6'h34] <= stage_q[23:16];
            regs_q[6'h35] <= stage_q[31:24];
            regs_q[6'h36] <= stage_q[39:32];
            regs_q[6'h37] <= stage_q[47:40];
         end
      end
   end

   assign spi_miso_oe = (state_q == DATA) && rw_q;
   assign spi_miso    = spi_miso_oe & miso_q;
   assign int1        = int1_q;
   assign reg_wr      = reg_wr_q;
   assign reg_wr_addr = wr_addr_q;
   assign reg_wr_data = wr_data_q;

endmodule
